// File: rtl/sync_fifo_fwft.sv
// Single-clock parametrised FIFO with optional first-word-fall-through output,
// programmable almost flags, occupancy count and overflow/underflow pulses.
module sync_fifo_fwft #(
   parameter int DSIZE     = 8,
   parameter int ASIZE     = 4,
   parameter int FWFT      = 0,
   parameter int AFULL_TH  = 14,
   parameter int AEMPTY_TH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [DSIZE-1:0] wr_data,
   input  logic             rd_en,
   output logic [DSIZE-1:0] rd_data,
   output logic             rd_valid,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [ASIZE:0]   count,
   output logic             overflow,
   output logic             underflow
);

   localparam int             DEPTH    = 1 << ASIZE;
   localparam logic [ASIZE:0] DEPTH_W  = (ASIZE+1)'(DEPTH);
   localparam logic [ASIZE:0] AFULL_W  = (ASIZE+1)'(AFULL_TH);
   localparam logic [ASIZE:0] AEMPTY_W = (ASIZE+1)'(AEMPTY_TH);

   logic [DSIZE-1:0] mem [DEPTH];

   logic [ASIZE:0]   wptr_reg;
   logic [ASIZE:0]   rptr_reg;
   logic [DSIZE-1:0] rd_data_reg;
   logic             rd_valid_reg;
   logic [ASIZE:0]   count_reg;
   logic             full_reg;
   logic             empty_reg;
   logic             afull_reg;
   logic             aempty_reg;
   logic             overflow_reg;
   logic             underflow_reg;

   logic [ASIZE:0]   mem_occ;
   logic [ASIZE:0]   mem_occ_next;
   logic [ASIZE:0]   count_next;
   logic             wr_ok;
   logic             mem_rd;
   logic             rd_valid_next;
   logic             underflow_next;
   logic             empty_next;

   // The extra pointer MSB makes the difference span 0..DEPTH without ambiguity.
   assign mem_occ      = wptr_reg - rptr_reg;
   assign wr_ok        = wr_en && !full_reg;
   assign mem_occ_next = mem_occ + (ASIZE+1)'(wr_ok) - (ASIZE+1)'(mem_rd);

   generate
      if (FWFT != 0) begin : g_fwft
         // Refill the output register whenever it is empty or being popped.
         always_comb begin
            mem_rd         = (!rd_valid_reg || rd_en) && (mem_occ != '0);
            rd_valid_next  = mem_rd || (rd_valid_reg && !rd_en);
            underflow_next = rd_en && !rd_valid_reg;
         end
         assign count_next = mem_occ_next + (ASIZE+1)'(rd_valid_next);
         assign empty_next = !rd_valid_next;
      end else begin : g_std
         always_comb begin
            mem_rd         = rd_en && (mem_occ != '0);
            rd_valid_next  = mem_rd;
            underflow_next = rd_en && (mem_occ == '0);
         end
         assign count_next = mem_occ_next;
         assign empty_next = (mem_occ_next == '0);
      end
   endgenerate

   // Storage is never cleared; only the pointers define what is readable.
   always_ff @(posedge clk) begin
      if (!rst && wr_ok) begin
         mem[wptr_reg[ASIZE-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_reg      <= '0;
         rptr_reg      <= '0;
         rd_data_reg   <= '0;
         rd_valid_reg  <= 1'b0;
         count_reg     <= '0;
         full_reg      <= 1'b0;
         empty_reg     <= 1'b1;
         afull_reg     <= 1'b0;
         aempty_reg    <= 1'b1;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         if (wr_ok) begin
            wptr_reg <= wptr_reg + 1'b1;
         end
         if (mem_rd) begin
            rptr_reg    <= rptr_reg + 1'b1;
            rd_data_reg <= mem[rptr_reg[ASIZE-1:0]];
         end
         rd_valid_reg  <= rd_valid_next;
         count_reg     <= count_next;
         full_reg      <= (mem_occ_next == DEPTH_W);
         empty_reg     <= empty_next;
         afull_reg     <= (count_next >= AFULL_W);
         aempty_reg    <= (count_next <= AEMPTY_W);
         overflow_reg  <= wr_en && full_reg;
         underflow_reg <= underflow_next;
      end
   end

   assign rd_data      = rd_data_reg;
   assign rd_valid     = rd_valid_reg;
   assign full         = full_reg;
   assign empty        = empty_reg;
   assign almost_full  = afull_reg;
   assign almost_empty = aempty_reg;
   assign count        = count_reg;
   assign overflow     = overflow_reg;
   assign underflow    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed bench for sync_fifo_fwft: one standard-mode and one FWFT instance,
// data checked against per-instance scoreboard queues.
module tb_sync_fifo_fwft;

   logic       clk = 1'b0;
   logic       rst;

   logic       s_wr_en, s_rd_en;
   logic [7:0] s_wr_data;
   logic [7:0] s_rd_data;
   logic       s_rd_valid, s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
   logic [4:0] s_count;

   logic       f_wr_en, f_rd_en;
   logic [7:0] f_wr_data;
   logic [7:0] f_rd_data;
   logic       f_rd_valid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
   logic [4:0] f_count;

   int tests = 0;
   int fails = 0;

   logic [7:0] q_s[$];
   logic [7:0] q_f[$];

   always #5 clk = ~clk;

   sync_fifo_fwft #(.DSIZE(8), .ASIZE(4), .FWFT(0), .AFULL_TH(14), .AEMPTY_TH(2)) u_std (
      .clk(clk), .rst(rst), .wr_en(s_wr_en), .wr_data(s_wr_data), .rd_en(s_rd_en),
      .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
      .almost_full(s_afull), .almost_empty(s_aempty), .count(s_count),
      .overflow(s_ovf), .underflow(s_udf)
   );

   sync_fifo_fwft #(.DSIZE(8), .ASIZE(4), .FWFT(1), .AFULL_TH(14), .AEMPTY_TH(2)) u_fwft (
      .clk(clk), .rst(rst), .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
      .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
      .almost_full(f_afull), .almost_empty(f_aempty), .count(f_count),
      .overflow(f_ovf), .underflow(f_udf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_std_data(input string tag);
      logic [7:0] e;
      if (q_s.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'(q_s.size()), 32'd1);
      end else begin
         e = q_s.pop_front();
         chk(tag, 32'(s_rd_data), 32'(e));
      end
   endtask

   task automatic chk_fwft_data(input string tag);
      logic [7:0] e;
      if (q_f.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'(q_f.size()), 32'd1);
      end else begin
         e = q_f.pop_front();
         chk(tag, 32'(f_rd_data), 32'(e));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      s_wr_en = 0; s_rd_en = 0; s_wr_data = 0;
      f_wr_en = 0; f_rd_en = 0; f_wr_data = 0;
      step(); step();
      rst = 1'b0;
      step();

      // Reset / idle state of both instances
      chk("s_rst_count", 32'(s_count), 0);
      chk("s_rst_empty", 32'(s_empty), 1);
      chk("s_rst_aempty", 32'(s_aempty), 1);
      chk("s_rst_full", 32'(s_full), 0);
      chk("s_rst_afull", 32'(s_afull), 0);
      chk("s_rst_valid", 32'(s_rd_valid), 0);
      chk("s_rst_data", 32'(s_rd_data), 0);
      chk("s_rst_ovf", 32'(s_ovf), 0);
      chk("s_rst_udf", 32'(s_udf), 0);
      chk("f_rst_count", 32'(f_count), 0);
      chk("f_rst_empty", 32'(f_empty), 1);
      chk("f_rst_aempty", 32'(f_aempty), 1);
      chk("f_rst_valid", 32'(f_rd_valid), 0);
      chk("f_rst_udf", 32'(f_udf), 0);

      // Standard mode: fill with 0x00..0x0F
      for (int i = 0; i < 16; i++) begin
         s_wr_en = 1; s_wr_data = 8'(i);
         q_s.push_back(8'(i));
         step();
         chk("s_fill_count", 32'(s_count), 32'(i + 1));
         chk("s_fill_afull", 32'(s_afull), 32'((i + 1) >= 14));
         chk("s_fill_aempty", 32'(s_aempty), 32'((i + 1) <= 2));
         chk("s_fill_full", 32'(s_full), 32'(i == 15));
      end
      s_wr_data = 8'hAA;
      step();
      chk("s_ovf_pulse", 32'(s_ovf), 1);
      chk("s_ovf_count", 32'(s_count), 16);
      s_wr_en = 0;
      step();
      chk("s_ovf_clear", 32'(s_ovf), 0);
      chk("s_ovf_count2", 32'(s_count), 16);

      for (int i = 0; i < 16; i++) begin
         s_rd_en = 1;
         step();
         chk("s_rd_valid", 32'(s_rd_valid), 1);
         chk_std_data("s_rd_data");
         chk("s_rd_count", 32'(s_count), 32'(15 - i));
         chk("s_rd_aempty", 32'(s_aempty), 32'((15 - i) <= 2));
         chk("s_rd_full", 32'(s_full), 0);
      end
      chk("s_drained_empty", 32'(s_empty), 1);

      // Standard mode: read on empty, then read with simultaneous write
      step();
      chk("s_udf_pulse", 32'(s_udf), 1);
      chk("s_udf_valid", 32'(s_rd_valid), 0);
      chk("s_udf_count", 32'(s_count), 0);
      s_rd_en = 0;
      step();
      chk("s_udf_clear", 32'(s_udf), 0);
      s_rd_en = 1; s_wr_en = 1; s_wr_data = 8'h77;
      q_s.push_back(8'h77);
      step();
      chk("s_wr_udf_pulse", 32'(s_udf), 1);
      chk("s_wr_udf_valid", 32'(s_rd_valid), 0);
      chk("s_wr_udf_count", 32'(s_count), 1);
      s_wr_en = 0;
      step();
      chk("s_wr_udf_rdvalid", 32'(s_rd_valid), 1);
      chk_std_data("s_wr_udf_data");
      chk("s_wr_udf_udf", 32'(s_udf), 0);
      s_rd_en = 0;
      step();

      // FWFT: single word fall-through latency
      f_wr_en = 1; f_wr_data = 8'h5A;
      q_f.push_back(8'h5A);
      step();
      chk("f_ft_k_valid", 32'(f_rd_valid), 0);
      chk("f_ft_k_count", 32'(f_count), 1);
      chk("f_ft_k_empty", 32'(f_empty), 1);
      f_wr_en = 0;
      step();
      chk("f_ft_k1_valid", 32'(f_rd_valid), 1);
      chk("f_ft_k1_count", 32'(f_count), 1);
      chk("f_ft_k1_empty", 32'(f_empty), 0);
      chk_fwft_data("f_ft_data");
      f_rd_en = 1;
      step();
      chk("f_pop_empty", 32'(f_empty), 1);
      chk("f_pop_count", 32'(f_count), 0);
      chk("f_pop_valid", 32'(f_rd_valid), 0);

      // FWFT: pop on empty, then with simultaneous write
      step();
      chk("f_udf_pulse", 32'(f_udf), 1);
      chk("f_udf_valid", 32'(f_rd_valid), 0);
      chk("f_udf_count", 32'(f_count), 0);
      f_wr_en = 1; f_wr_data = 8'h11;
      q_f.push_back(8'h11);
      step();
      chk("f_wr_udf_pulse", 32'(f_udf), 1);
      chk("f_wr_udf_count", 32'(f_count), 1);
      f_wr_en = 0; f_rd_en = 0;
      step();
      chk("f_wr_udf_valid", 32'(f_rd_valid), 1);
      chk("f_wr_udf_clear", 32'(f_udf), 0);
      chk_fwft_data("f_wr_udf_data");
      f_rd_en = 1;
      step();
      chk("f_wr_udf_empty", 32'(f_empty), 1);
      f_rd_en = 0;

      // FWFT: fill to DEPTH+1
      for (int i = 0; i < 17; i++) begin
         f_wr_en = 1; f_wr_data = 8'(8'h20 + i);
         q_f.push_back(8'(8'h20 + i));
         step();
         chk("f_fill_count", 32'(f_count), 32'(i + 1));
      end
      chk("f_fill_full", 32'(f_full), 1);
      chk("f_fill_afull", 32'(f_afull), 1);

      // FWFT: 40 cycles of simultaneous write and pop
      for (int i = 0; i < 40; i++) begin
         f_wr_en = 1; f_rd_en = 1; f_wr_data = 8'(8'h40 + i);
         chk("f_str_valid", 32'(f_rd_valid), 1);
         chk_fwft_data("f_str_data");
         if (i != 0) q_f.push_back(8'(8'h40 + i));
         step();
         chk("f_str_ovf", 32'(f_ovf), 32'(i == 0));
         chk("f_str_count", 32'(f_count), 16);
      end

      // FWFT: back-to-back drain
      f_wr_en = 0;
      for (int i = 0; i < 16; i++) begin
         chk("f_drn_valid", 32'(f_rd_valid), 1);
         chk_fwft_data("f_drn_data");
         step();
         chk("f_drn_count", 32'(f_count), 32'(15 - i));
      end
      chk("f_drn_empty", 32'(f_empty), 1);
      chk("f_drn_aempty", 32'(f_aempty), 1);
      chk("f_drn_sb", 32'(q_f.size()), 0);
      f_rd_en = 0;
      step();

      // Reset mid-operation with 9 words held
      for (int i = 0; i < 9; i++) begin
         s_wr_en = 1; s_wr_data = 8'(8'h80 + i);
         f_wr_en = 1; f_wr_data = 8'(8'h90 + i);
         step();
      end
      chk("s_pre_rst_count", 32'(s_count), 9);
      chk("f_pre_rst_count", 32'(f_count), 9);
      rst = 1; s_wr_data = 8'hEE; f_wr_data = 8'hEE;
      step();
      chk("s_mid_rst_count", 32'(s_count), 0);
      chk("s_mid_rst_empty", 32'(s_empty), 1);
      chk("f_mid_rst_count", 32'(f_count), 0);
      chk("f_mid_rst_empty", 32'(f_empty), 1);
      chk("f_mid_rst_valid", 32'(f_rd_valid), 0);
      rst = 0;
      q_s.delete(); q_f.delete();
      s_wr_data = 8'h33; f_wr_data = 8'h33;
      q_s.push_back(8'h33); q_f.push_back(8'h33);
      step();
      chk("s_post_rst_count", 32'(s_count), 1);
      s_wr_en = 0; f_wr_en = 0; s_rd_en = 1;
      step();
      chk("s_post_rst_valid", 32'(s_rd_valid), 1);
      chk_std_data("s_post_rst_data");
      chk("f_post_rst_valid", 32'(f_rd_valid), 1);
      chk_fwft_data("f_post_rst_data");
      s_rd_en = 0;
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sync_fifo_fwft.md
# sync_fifo_fwft

Single-clock, parametrised FIFO for the DSP_Img pixel and coefficient datapaths, used where producer and consumer share a clock. It replaces ad-hoc line buffers between processing stages. Beyond plain buffering it adds:
- a first-word-fall-through (FWFT) mode;
- programmable almost-full and almost-empty thresholds;
- an occupancy count;
- overflow and underflow error pulses.

## Interface
Parameters:
- DSIZE, 8, data word width in bits
- ASIZE, 4, address width; DEPTH = 2^ASIZE memory words
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
- AFULL_TH, 14, almost_full asserts when count >= AFULL_TH
- AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH
- Legal range: ASIZE >= 2 and 1 <= AEMPTY_TH < AFULL_TH <= DEPTH

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- wr_data  in  DSIZE  write word
- rd_en  in  1  read request in standard mode; pop/acknowledge in FWFT mode
- rd_data  out  DSIZE  read word, registered
- rd_valid  out  1  rd_data holds a valid word
- full  out  1  memory holds DEPTH words; writes refused
- empty  out  1  no readable word
- almost_full  out  1  threshold flag
- almost_empty  out  1  threshold flag
- count  out  ASIZE+1  words held, including the FWFT output register
- overflow  out  1  one-cycle pulse when a write is refused
- underflow  out  1  one-cycle pulse when a read is refused

## Operation
- Storage: DEPTH-word memory, ASIZE+1-bit binary write and read pointers. The extra MSB distinguishes full from empty.
  - mem_occ = wptr - rptr, modulo 2^(ASIZE+1).
  - Pointers wrap naturally.
- Write accept: wr_en && !full. Refused writes do not change state and raise overflow for one cycle.
  - There is no write-through while full, even if a read is accepted in the same cycle.
- Standard mode (FWFT=0):
  - Read accept: rd_en && !empty. Memory word at rptr goes to rd_data and rd_valid pulses high.
  - rd_valid pulses for exactly one cycle per accepted read.
  - empty = (mem_occ == 0). count = mem_occ.
- FWFT mode (FWFT=1): the output register holds the head word.
  - Prefetch: when the output register is empty, or is being popped this cycle, and mem_occ > 0, the head is loaded from memory.
  - rd_valid stays high while a word is presented.
  - rd_en && rd_valid pops the word. rd_en && !rd_valid is refused and raises underflow.
  - empty = !rd_valid. count = mem_occ + rd_valid, so the maximum is DEPTH+1.
- Flags:
  - full = (mem_occ == DEPTH).
  - almost_full and almost_empty are derived from the next-state count.
- Simultaneous accepted write and read: mem_occ is unchanged.
  - Write into an empty FIFO with rd_en in the same cycle: the read is refused and underflow pulses, in both modes.
- Arithmetic: all pointer and count arithmetic is unsigned, at ASIZE+1 bits. count never wraps.

## Timing
- All outputs are registered and update on the rising clk edge. No combinational input-to-output paths.
- Reset values:
  - count = 0, empty = 1, full = 0
  - almost_empty = 1, almost_full = 0
  - rd_valid = 0, rd_data = 0
  - overflow = 0, underflow = 0
  - both pointers = 0
  - Memory contents are not cleared.
- Reset mid-operation discards all contents from the next cycle. rd_valid drops immediately, and inputs are ignored during rst.
- Standard mode: read accepted at edge k gives rd_data and rd_valid valid after edge k. Read latency is 1.
- FWFT mode: first write into an empty FIFO at edge k gives rd_valid = 1 after edge k+1. Fall-through latency is 2.
  - Back-to-back pops sustain one word per cycle while mem_occ > 0.
- Flag timing: count, full, empty, almost_* and overflow/underflow change on the same edge as the accepting or refusing transaction.
- Throughput: one write and one read per cycle.

## Test plan
Conditions: DSIZE=8, ASIZE=4, AFULL_TH=14, AEMPTY_TH=2.
- Reset, then idle: count=0, empty=1, almost_empty=1, full=0, rd_valid=0, overflow=0, underflow=0.
- FWFT=0, write 0x00..0x0F over 16 cycles:
  - full=1 and count=16 after the 16th edge; almost_full set when count reaches 14.
  - A 17th write of 0xAA gives overflow for one cycle and count stays 16.
  - Reading 16 words returns 0x00..0x0F in order with latency 1.
- FWFT=1, single write 0x5A at edge k: rd_valid=1 and rd_data=0x5A after edge k+1, count=1. Pop gives empty=1 and count=0.
- FWFT=1, fill to count=17, then wr_en and rd_en asserted every cycle for 40 cycles with an incrementing pattern:
  - Output stream is in order with no gaps.
  - count stays 16–17 (16 after first cycle: read accepted, write refused while full, overflow pulses once; then steady).
  - Pointers wrap at least twice.
- Read on empty in both modes: underflow for one cycle, rd_valid=0, count stays 0. Same result with wr_en in the same cycle; count becomes 1 afterwards.
- Assert rst with count=9: after the edge, count=0 and empty=1. The next write of 0x33 is read back as the first word.
